// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: serialises the set bits of a request vector into
// binary indices, lowest index first, one index per output handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request-vector handshake; in_bits sampled on accept
//   out_valid/out_ready index handshake
//   out_code            index of the lowest pending set bit
//   out_last            out_code is the final index of the current vector
//   zero_drop           one-cycle pulse after an all-zero vector is discarded
module onehot_encoder_seq #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              zero_drop
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  pending_q;
    logic [WIDTH-1:0]  pending_d;
    logic              zero_drop_q;
    logic              zero_drop_d;
    logic [WIDTH-1:0]  rest;
    logic [CODE_W-1:0] low_idx;

    // x & (x - 1) clears the lowest set bit; an all-zero result means the
    // bit being presented now is the only one left.
    assign rest = pending_q & (pending_q - WIDTH'(1));

    // Lowest-index-wins priority encoder: scan downward so the lowest set
    // bit is the last assignment made.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = CODE_W'(i);
            end
        end
    end

    // Next-state and output decode. All out_* signals depend only on
    // state_q and pending_q, never on the in_* inputs.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_code    = '0;
        out_last    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_bits != '0) begin
                        pending_d = in_bits;
                        state_d   = EMIT;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_code  = low_idx;
                out_last  = (rest == '0);
                if (out_ready) begin
                    pending_d = rest;
                    if (rest == '0) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// tb_onehot_encoder_seq: directed and randomized checks of onehot_encoder_seq
// against a set-bit-list reference model.
module tb_onehot_encoder_seq;

    localparam int WIDTH  = 8;
    localparam int CODE_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_bits;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              zero_drop;

    int n_tests = 0;
    int n_fail  = 0;

    int got_codes[$];
    bit got_lasts[$];
    int exp_codes[$];
    bit timed_out;

    onehot_encoder_seq #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the list of set-bit positions in ascending order.
    function automatic void model(input logic [WIDTH-1:0] v);
        exp_codes = {};
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) exp_codes.push_back(i);
        end
    endfunction

    task automatic accept(input logic [WIDTH-1:0] v);
        in_valid = 1'b1;
        in_bits  = v;
        step();
        in_valid = 1'b0;
        in_bits  = WIDTH'($urandom);
    endtask

    // Records every transferred index until the last one, with random
    // out_ready; optionally scrambles in_bits each cycle.
    task automatic collect(input int pct, input bit scramble);
        bit fire;
        bit fin;
        got_codes = {};
        got_lasts = {};
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            if (scramble) in_bits = WIDTH'($urandom);
            fire = out_valid && out_ready;
            fin  = fire && out_last;
            if (fire) begin
                got_codes.push_back(int'(out_code));
                got_lasts.push_back(out_last);
            end
            step();
            if (fin) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_code !== 3'd0 ||
            out_last !== 1'b0 || zero_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b code=%0d last=%b zd=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_code, out_last, zero_drop);
        end
    endtask

    task automatic test_onehot();
        logic [WIDTH-1:0] v;
        out_ready = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            v = WIDTH'(1) << i;
            accept(v);
            n_tests++;
            if (out_valid !== 1'b1 || out_code !== CODE_W'(i) ||
                out_last !== 1'b1 || (WIDTH'(1) << out_code) !== v) begin
                n_fail++;
                $display("FAIL onehot_%0d: vld=%b code=%0d last=%b required 1 %0d 1",
                         i, out_valid, out_code, out_last, i);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL onehot_done_%0d: vld=%b rdy=%b required 0 1",
                         i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_pattern_a5();
        model(8'hA5);
        out_ready = 1'b1;
        accept(8'hA5);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_code !== CODE_W'(exp_codes[k]) ||
                out_last !== 1'(k == 3)) begin
                n_fail++;
                $display("FAIL a5_%0d: vld=%b rdy=%b code=%0d last=%b required 1 0 %0d %0d",
                         k, out_valid, in_ready, out_code, out_last,
                         exp_codes[k], (k == 3));
            end
            step();
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure_ff();
        int idx;
        idx = 0;
        out_ready = 1'b0;
        accept(8'hFF);
        for (int c = 0; c < 40 && idx < 8; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            n_tests++;
            if (out_valid !== 1'b1 || out_code !== CODE_W'(idx) ||
                out_last !== 1'(idx == 7)) begin
                n_fail++;
                $display("FAIL ff_cyc%0d: vld=%b code=%0d last=%b required 1 %0d %0d",
                         c, out_valid, out_code, out_last, idx, (idx == 7));
            end
            if (out_ready) idx++;
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (idx != 8 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_done: count=%0d vld=%b rdy=%b required 8 0 1",
                     idx, out_valid, in_ready);
        end
    endtask

    task automatic test_zero_drop();
        accept(8'h00);
        n_tests++;
        if (zero_drop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_pulse: zd=%b vld=%b rdy=%b required 1 0 1",
                     zero_drop, out_valid, in_ready);
        end
        out_ready = 1'b1;
        accept(8'h10);
        n_tests++;
        if (zero_drop !== 1'b0 || out_valid !== 1'b1 || out_code !== 3'd4 ||
            out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_followup: zd=%b vld=%b code=%0d last=%b required 0 1 4 1",
                     zero_drop, out_valid, out_code, out_last);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_emit();
        out_ready = 1'b1;
        accept(8'hC3);
        n_tests++;
        if (out_valid !== 1'b1 || out_code !== 3'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_first: vld=%b code=%0d last=%b required 1 0 0",
                     out_valid, out_code, out_last);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_code !== 3'd0 ||
            out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: vld=%b rdy=%b code=%0d last=%b required 0 1 0 0",
                     out_valid, in_ready, out_code, out_last);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: vld=%b required 0", out_valid);
        end
        accept(8'h08);
        n_tests++;
        if (out_valid !== 1'b1 || out_code !== 3'd3 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_fresh: vld=%b code=%0d last=%b required 1 3 1",
                     out_valid, out_code, out_last);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_done: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_input_change();
        logic [WIDTH-1:0] v;
        bit bad;
        for (int t = 0; t < 8; t++) begin
            v = WIDTH'($urandom_range(1, 255));
            model(v);
            in_valid = 1'b1;
            in_bits  = v;
            step();
            collect(50, 1'b1);
            in_valid = 1'b0;
            bad = timed_out || (got_codes.size() != exp_codes.size());
            for (int k = 0; k < got_codes.size() && !bad; k++) begin
                if (got_codes[k] != exp_codes[k] ||
                    got_lasts[k] != (k == exp_codes.size() - 1)) bad = 1'b1;
            end
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL change_%0d: v=%h got %0d codes timeout=%b required %0d codes",
                         t, v, got_codes.size(), timed_out, exp_codes.size());
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        bit bad;
        for (int t = 0; t < 40; t++) begin
            v = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_ready_%0d: rdy=%b required 1", t, in_ready);
            end
            accept(v);
            if (v == '0) begin
                n_tests++;
                if (zero_drop !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_zero_%0d: zd=%b vld=%b required 1 0",
                             t, zero_drop, out_valid);
                end
                step();
            end else begin
                model(v);
                collect($urandom_range(30, 100), 1'b0);
                bad = timed_out || (got_codes.size() != exp_codes.size());
                for (int k = 0; k < got_codes.size() && !bad; k++) begin
                    if (got_codes[k] != exp_codes[k] ||
                        got_lasts[k] != (k == exp_codes.size() - 1)) bad = 1'b1;
                end
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL rand_seq_%0d: v=%h got %0d codes timeout=%b required %0d codes",
                             t, v, got_codes.size(), timed_out, exp_codes.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_pattern_a5();
        test_backpressure_ff();
        test_zero_drop();
        test_reset_mid_emit();
        test_input_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
